// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux_scan_sel block: mode encoding, scan
// state classification and the mask search helper.
package mux_scan_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    IDLE_SCAN = 2'd0,
    DWELL     = 2'd1,
    STEP      = 2'd2
  } scan_state_e;

  // Next set mask bit strictly above ptr, wrapping to the lowest set bit.
  // Returns ptr unchanged when no bit in the first n_ch positions is set.
  function automatic logic [3:0] next_set_bit(input logic [15:0] mask,
                                              input logic [3:0]  ptr,
                                              input int          n_ch);
    logic [3:0] res;
    logic       found;
    res   = ptr;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!found && (i < n_ch) && (i > int'(ptr)) && mask[i]) begin
        res   = 4'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < 16; i++) begin
      if (!found && (i < n_ch) && mask[i]) begin
        res   = 4'(i);
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_scan_sel_ptr.sv
// Scan pointer, dwell counter and wrap detection for mux_scan_sel.
//
// state     | meaning
// IDLE_SCAN | no channel enabled in ch_mask; pointer and count hold
// DWELL     | holding current channel, dwell count advancing
// STEP      | dwell finished (or entry on a masked channel); load next channel
//
// The state is decoded each cycle from the registered pointer/count and the
// live mask/dwell inputs, so a dwell shortened below the current count steps
// on the very next enabled cycle.
module mux_scan_ptr
  import mux_scan_pkg::*;
#(
  parameter  int N_CH      = 4,
  parameter  int DWELL_W   = 4,
  parameter  int MSB_FIRST = 1,
  localparam int SEL_W     = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N_CH-1:0]    ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   ptr_nxt_o,
  output logic [SEL_W-1:0]   phys_o,
  output logic               wrap_o,
  output logic               idle_o
);

  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic               mode_q, mode_d;
  logic [SEL_W-1:0]   start_p;
  logic [SEL_W-1:0]   base;
  logic [SEL_W-1:0]   nxt;
  logic               entry;
  logic               wrap;
  scan_state_e        st;

  // Physical channel from sel; out-of-range sel clamps to the top channel.
  always_comb begin
    start_p = sel;
    if (int'(sel) >= N_CH) begin
      start_p = SEL_W'(N_CH - 1);
    end else if (MSB_FIRST != 0) begin
      start_p = SEL_W'(N_CH - 1 - int'(sel));
    end
  end

  assign entry = (mode_q == MODE_MANUAL) && (mode == MODE_SCAN);
  assign base  = entry ? start_p : ptr_q;
  assign nxt   = SEL_W'(next_set_bit(16'(ch_mask), 4'(base), N_CH));

  // Scan state decode.
  always_comb begin
    st = DWELL;
    if (ch_mask == '0) begin
      st = IDLE_SCAN;
    end else if (entry) begin
      st = ch_mask[start_p] ? DWELL : STEP;
    end else if (dwell_cnt_q >= dwell) begin
      st = STEP;
    end
  end

  // Next pointer, count and wrap pulse.
  always_comb begin
    ptr_d       = ptr_q;
    dwell_cnt_d = dwell_cnt_q;
    mode_d      = mode_q;
    wrap        = 1'b0;
    if (en) begin
      mode_d = mode;
      if (mode == MODE_SCAN) begin
        if (entry) begin
          ptr_d       = start_p;
          dwell_cnt_d = '0;
        end
        case (st)
          IDLE_SCAN: ;
          DWELL: begin
            if (!entry) dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
          end
          STEP: begin
            ptr_d       = nxt;
            dwell_cnt_d = '0;
            wrap        = (nxt < base);
          end
          default: ;
        endcase
      end
    end
  end

  // Pointer, count and previous-mode registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      dwell_cnt_q <= '0;
      mode_q      <= MODE_MANUAL;
    end else begin
      ptr_q       <= ptr_d;
      dwell_cnt_q <= dwell_cnt_d;
      mode_q      <= mode_d;
    end
  end

  assign ptr_nxt_o = ptr_d;
  assign phys_o    = start_p;
  assign wrap_o    = wrap;
  assign idle_o    = (ch_mask == '0);

endmodule

// File: rtl/mux_scan_sel.sv
// N:1 registered channel multiplexer with manual select and automatic
// masked channel scan. Optional macro MUX_SCAN_PARITY_EN adds a registered
// even-parity output dout_par alongside dout.
module mux_scan_sel
  import mux_scan_pkg::*;
#(
  parameter  int N_CH      = 4,
  parameter  int W         = 1,
  parameter  int DWELL_W   = 4,
  parameter  int MSB_FIRST = 1,
  localparam int SEL_W     = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic [N_CH*W-1:0]   din,
  input  logic [N_CH-1:0]     ch_mask,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [W-1:0]        dout,
  output logic [SEL_W-1:0]    ch_idx,
  output logic                valid,
  output logic                sel_err,
`ifdef MUX_SCAN_PARITY_EN
  output logic                dout_par,
`endif
  output logic                scan_wrap
);

  logic [W-1:0]     dout_q, dout_d;
  logic [SEL_W-1:0] ch_idx_q, ch_idx_d;
  logic             valid_q, valid_d;
  logic             sel_err_q, sel_err_d;
  logic             scan_wrap_q, scan_wrap_d;
  logic [SEL_W-1:0] ptr_nxt;
  logic [SEL_W-1:0] phys;
  logic             wrap;
  logic             idle;
  logic             sel_bad;

  mux_scan_ptr #(
    .N_CH      (N_CH),
    .DWELL_W   (DWELL_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_ptr (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .sel       (sel),
    .ch_mask   (ch_mask),
    .dwell     (dwell),
    .ptr_nxt_o (ptr_nxt),
    .phys_o    (phys),
    .wrap_o    (wrap),
    .idle_o    (idle)
  );

  assign sel_bad = (int'(sel) >= N_CH);

  // Output selection; scan follows the pointer as it is loaded so ch_idx
  // and dout always match the registered scan pointer.
  always_comb begin
    dout_d      = dout_q;
    ch_idx_d    = ch_idx_q;
    valid_d     = valid_q;
    sel_err_d   = sel_err_q;
    scan_wrap_d = 1'b0;
    if (en) begin
      if (mode == MODE_SCAN) begin
        sel_err_d   = 1'b0;
        scan_wrap_d = wrap;
        if (idle) begin
          dout_d  = '0;
          valid_d = 1'b0;
        end else begin
          ch_idx_d = ptr_nxt;
          dout_d   = din[int'(ptr_nxt)*W +: W];
          valid_d  = 1'b1;
        end
      end else if (sel_bad) begin
        dout_d    = '0;
        valid_d   = 1'b0;
        sel_err_d = 1'b1;
      end else begin
        ch_idx_d  = phys;
        dout_d    = din[int'(phys)*W +: W];
        valid_d   = 1'b1;
        sel_err_d = 1'b0;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q      <= '0;
      ch_idx_q    <= '0;
      valid_q     <= 1'b0;
      sel_err_q   <= 1'b0;
      scan_wrap_q <= 1'b0;
    end else begin
      dout_q      <= dout_d;
      ch_idx_q    <= ch_idx_d;
      valid_q     <= valid_d;
      sel_err_q   <= sel_err_d;
      scan_wrap_q <= scan_wrap_d;
    end
  end

  assign dout      = dout_q;
  assign ch_idx    = ch_idx_q;
  assign valid     = valid_q;
  assign sel_err   = sel_err_q;
  assign scan_wrap = scan_wrap_q;

`ifdef MUX_SCAN_PARITY_EN
  logic par_q, par_d;

  assign par_d = valid_d ? (^dout_d) : 1'b0;

  // Parity register, aligned with dout.
  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end

  assign dout_par = par_q;
`endif

endmodule

// File: tb/tb_mux_scan_sel.sv
module tb_mux_scan_sel;
  import mux_scan_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, mode;
  logic [1:0] sel;
  logic [3:0] mask4;
  logic [2:0] mask3;
  logic [3:0] dwell;
  logic [3:0]  din1;
  logic [7:0]  ch8 [4];
  logic [31:0] din8;
  logic [23:0] din3;

  assign din8 = {ch8[3], ch8[2], ch8[1], ch8[0]};

  logic       m4_dout, m4_valid, m4_err, m4_wrap, m4_par;
  logic [1:0] m4_idx;
  logic [7:0] s4_dout;
  logic       s4_valid, s4_err, s4_wrap, s4_par;
  logic [1:0] s4_idx;
  logic [7:0] m3_dout;
  logic       m3_valid, m3_err, m3_wrap, m3_par;
  logic [1:0] m3_idx;

  mux_scan_sel #(.N_CH(4), .W(1), .DWELL_W(4), .MSB_FIRST(1)) u_m4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .din(din1),
    .ch_mask(mask4), .dwell(dwell), .dout(m4_dout), .ch_idx(m4_idx),
    .valid(m4_valid), .sel_err(m4_err),
`ifdef MUX_SCAN_PARITY_EN
    .dout_par(m4_par),
`endif
    .scan_wrap(m4_wrap));

  mux_scan_sel #(.N_CH(4), .W(8), .DWELL_W(4), .MSB_FIRST(1)) u_s4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .din(din8),
    .ch_mask(mask4), .dwell(dwell), .dout(s4_dout), .ch_idx(s4_idx),
    .valid(s4_valid), .sel_err(s4_err),
`ifdef MUX_SCAN_PARITY_EN
    .dout_par(s4_par),
`endif
    .scan_wrap(s4_wrap));

  mux_scan_sel #(.N_CH(3), .W(8), .DWELL_W(4), .MSB_FIRST(0)) u_m3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .din(din3),
    .ch_mask(mask3), .dwell(dwell), .dout(m3_dout), .ch_idx(m3_idx),
    .valid(m3_valid), .sel_err(m3_err),
`ifdef MUX_SCAN_PARITY_EN
    .dout_par(m3_par),
`endif
    .scan_wrap(m3_wrap));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] sel;
    logic [7:0] dout;
    logic [1:0] idx;
    logic       valid;
    logic       err;
  } man_vec_t;

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] mask;
    logic [3:0] dwell;
    logic       en;
    logic       v;
    logic [1:0] idx;
    logic       w;
  } scan_vec_t;

  man_vec_t  m4v [4];
  man_vec_t  m3v [3];
  scan_vec_t sq  [$];

  initial begin
    logic [7:0] exp_d;

    // manual 4:1, W=1, din=1010, MSB_FIRST: sel k -> channel 3-k
    m4v[0] = '{2'd0, 8'd1, 2'd3, 1'b1, 1'b0};
    m4v[1] = '{2'd1, 8'd0, 2'd2, 1'b1, 1'b0};
    m4v[2] = '{2'd2, 8'd1, 2'd1, 1'b1, 1'b0};
    m4v[3] = '{2'd3, 8'd0, 2'd0, 1'b1, 1'b0};
    // manual 3:1, LSB ordering; sel=3 out of range, ch_idx holds
    m3v[0] = '{2'd2, 8'h77, 2'd2, 1'b1, 1'b0};
    m3v[1] = '{2'd3, 8'h00, 2'd2, 1'b0, 1'b1};
    m3v[2] = '{2'd1, 8'h66, 2'd1, 1'b1, 1'b0};

    // scan, mask 1111, dwell 2, sel 3 -> start channel 0
    for (int k = 0; k < 13; k++)
      sq.push_back('{1'b1, 2'd3, 4'hF, 4'd2, 1'b1, 1'b1,
                     (k < 12) ? 2'(k / 3) : 2'd0, (k == 12)});
    // mask 0101, dwell 0: alternate 2,0 with wrap on each 2->0
    for (int k = 0; k < 5; k++)
      sq.push_back('{1'b1, 2'd3, 4'h5, 4'd0, 1'b1, 1'b1,
                     (k % 2 == 0) ? 2'd2 : 2'd0, (k % 2 == 1)});
    // empty mask: invalid, pointer holds at 2
    for (int k = 0; k < 2; k++)
      sq.push_back('{1'b1, 2'd3, 4'h0, 4'd0, 1'b1, 1'b0, 2'd2, 1'b0});
    // mask restored: steps from held pointer 2, wraps to 0
    sq.push_back('{1'b1, 2'd3, 4'h5, 4'd0, 1'b1, 1'b1, 2'd0, 1'b1});
    // dwell 5 with en low 4 cycles: frozen, wrap cleared
    for (int k = 0; k < 4; k++)
      sq.push_back('{1'b1, 2'd3, 4'h5, 4'd5, 1'b0, 1'b1, 2'd0, 1'b0});
    for (int k = 0; k < 5; k++)
      sq.push_back('{1'b1, 2'd3, 4'h5, 4'd5, 1'b1, 1'b1, 2'd0, 1'b0});
    sq.push_back('{1'b1, 2'd3, 4'h5, 4'd5, 1'b1, 1'b1, 2'd2, 1'b0});

    ch8[0] = 8'h10; ch8[1] = 8'h21; ch8[2] = 8'h32; ch8[3] = 8'h43;
    din1  = 4'b1010;
    din3  = {8'h77, 8'h66, 8'h55};
    rst   = 1'b1;
    en    = 1'b1;
    mode  = 1'b0;
    sel   = 2'd0;
    mask4 = 4'h0;
    mask3 = 3'b111;
    dwell = 4'd0;
    tick();
    tick();

    chk("rst m4 dout",  32'(m4_dout),  0);
    chk("rst m4 idx",   32'(m4_idx),   0);
    chk("rst s4 dout",  32'(s4_dout),  0);
    chk("rst s4 valid", 32'(s4_valid), 0);
    chk("rst s4 err",   32'(s4_err),   0);
    chk("rst s4 wrap",  32'(s4_wrap),  0);
    chk("rst s4 ptr",   32'(u_s4.u_ptr.ptr_q), 0);
`ifdef MUX_SCAN_PARITY_EN
    chk("rst s4 par",   32'(s4_par),   0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      sel = m4v[i].sel;
      tick();
      chk($sformatf("m4[%0d] dout", i),  32'(m4_dout),  32'(m4v[i].dout));
      chk($sformatf("m4[%0d] idx", i),   32'(m4_idx),   32'(m4v[i].idx));
      chk($sformatf("m4[%0d] valid", i), 32'(m4_valid), 32'(m4v[i].valid));
      chk($sformatf("m4[%0d] err", i),   32'(m4_err),   32'(m4v[i].err));
    end

    for (int i = 0; i < 3; i++) begin
      sel = m3v[i].sel;
      tick();
      chk($sformatf("m3[%0d] dout", i),  32'(m3_dout),  32'(m3v[i].dout));
      chk($sformatf("m3[%0d] idx", i),   32'(m3_idx),   32'(m3v[i].idx));
      chk($sformatf("m3[%0d] valid", i), 32'(m3_valid), 32'(m3v[i].valid));
      chk($sformatf("m3[%0d] err", i),   32'(m3_err),   32'(m3v[i].err));
    end

`ifdef MUX_SCAN_PARITY_EN
    sel = 2'd3;
    ch8[0] = 8'hA7;
    tick();
    chk("par A7 dout", 32'(s4_dout), 32'hA7);
    chk("par A7",      32'(s4_par),  1);
    ch8[0] = 8'h3C;
    tick();
    chk("par 3C",      32'(s4_par),  0);
    ch8[0] = 8'h10;
`endif

    for (int i = 0; i < sq.size(); i++) begin
      mode  = sq[i].mode;
      sel   = sq[i].sel;
      mask4 = sq[i].mask;
      dwell = sq[i].dwell;
      en    = sq[i].en;
      tick();
      exp_d = sq[i].v ? ch8[sq[i].idx] : 8'h00;
      chk($sformatf("scan[%0d] idx", i),   32'(s4_idx),   32'(sq[i].idx));
      chk($sformatf("scan[%0d] valid", i), 32'(s4_valid), 32'(sq[i].v));
      chk($sformatf("scan[%0d] dout", i),  32'(s4_dout),  32'(exp_d));
      chk($sformatf("scan[%0d] wrap", i),  32'(s4_wrap),  32'(sq[i].w));
      chk($sformatf("scan[%0d] err", i),   32'(s4_err),   0);
    end

    // scan -> manual takes effect immediately; pointer is kept
    mode = 1'b0;
    sel  = 2'd0;
    tick();
    chk("s2m idx",  32'(s4_idx),  3);
    chk("s2m dout", 32'(s4_dout), 32'h43);
    chk("s2m ptr",  32'(u_s4.u_ptr.ptr_q), 2);

    // reset in the middle of a scan
    mode  = 1'b1;
    mask4 = 4'hF;
    dwell = 4'd3;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mrst dout",  32'(s4_dout),  0);
    chk("mrst idx",   32'(s4_idx),   0);
    chk("mrst valid", 32'(s4_valid), 0);
    chk("mrst wrap",  32'(s4_wrap),  0);
    chk("mrst ptr",   32'(u_s4.u_ptr.ptr_q), 0);
    rst  = 1'b0;
    mode = 1'b0;
    sel  = 2'd1;
    tick();
    chk("post rst idx",  32'(s4_idx),  2);
    chk("post rst dout", 32'(s4_dout), 32'h32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
